// File: rtl/usb_fifo_arbiter.sv
// usb_fifo_arbiter: shares the FX2 slave-FIFO bus between up to two host-to-FPGA
// (RX, EP2/EP4) and two FPGA-to-host (TX, EP6/EP8) streams.
// A round-robin grant holds the bus for at most BURST words.
// A partial IN packet left idle for FLUSH_TIMEOUT cycles is committed with PKTEND.
module usb_fifo_arbiter #(
  parameter int WIDTH         = 8,
  parameter int NUM_CH        = 2,
  parameter int BURST         = 64,
  parameter int PKT_WORDS     = 256,
  parameter int FLUSH_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [1:0]              usb_addr,
  output logic                    usb_sloe,
  output logic                    usb_slrd,
  output logic                    usb_slwr,
  output logic                    usb_pktend,
  output logic [WIDTH-1:0]        usb_data_in,
  input  logic [WIDTH-1:0]        usb_data_out,
  input  logic [1:0]              usb_ep_empty,
  input  logic [1:0]              usb_ep_full,
  output logic [NUM_CH*WIDTH-1:0] rx_data,
  output logic [NUM_CH-1:0]       rx_valid,
  input  logic [NUM_CH-1:0]       rx_ready,
  input  logic [NUM_CH*WIDTH-1:0] tx_data,
  input  logic [NUM_CH-1:0]       tx_valid,
  output logic [NUM_CH-1:0]       tx_ready
);

  localparam int PCW = (PKT_WORDS > 256) ? $clog2(PKT_WORDS) : 8;
  localparam int IW  = $clog2(FLUSH_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RD_SEL, RD, WR, PKTEND, GAP} state_e;

  state_e         state_q, state_d;
  logic [1:0]     ptr_q, ptr_d;        // slot searched first: 0=RX0 1=RX1 2=TX0 3=TX1
  logic           ch_q, ch_d;          // channel owning the current grant
  logic [8:0]     burst_q, burst_d;    // words moved in the current grant
  logic [PCW-1:0] pcnt_q [2];
  logic [PCW-1:0] pcnt_d [2];
  logic [IW-1:0]  idle_q [2];
  logic [IW-1:0]  idle_d [2];

  // Stream ports padded to two channels so absent channels read as inactive.
  logic [1:0]         rx_ready_w, tx_valid_w, rx_valid_w, tx_ready_w, flush_due;
  logic [2*WIDTH-1:0] tx_data_w, rx_data_w;
  logic [3:0]         elig;
  logic               gnt_found;
  logic [1:0]         gnt_slot;

  // Pad the per-channel inputs to the two-channel internal view.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    rx_ready_w = '0;
    tx_valid_w = '0;
    tx_data_w  = '0;
    rx_ready_w[NUM_CH-1:0]       = rx_ready;
    tx_valid_w[NUM_CH-1:0]       = tx_valid;
    tx_data_w[NUM_CH*WIDTH-1:0]  = tx_data;
  end

  // Round-robin search over the four slots, starting at ptr_q.
  always_comb begin
    logic [1:0] slot;
    for (int c = 0; c < 2; c++) flush_due[c] = (idle_q[c] == IW'(FLUSH_TIMEOUT));
    elig[0] = !usb_ep_empty[0] && rx_ready_w[0];
    elig[1] = !usb_ep_empty[1] && rx_ready_w[1] && (NUM_CH > 1);
    elig[2] = !usb_ep_full[0] && (tx_valid_w[0] || flush_due[0]);
    elig[3] = !usb_ep_full[1] && (tx_valid_w[1] || flush_due[1]) && (NUM_CH > 1);
    gnt_found = 1'b0;
    gnt_slot  = ptr_q;
    slot      = ptr_q;
    for (int i = 0; i < 4; i++) begin
      slot = ptr_q + 2'(i);
      if (!gnt_found && elig[slot]) begin
        gnt_found = 1'b1;
        gnt_slot  = slot;
      end
    end
  end

  // Next-state and bus/stream outputs; every output is idle outside its own state.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ch_d        = ch_q;
    burst_d     = burst_q;
    usb_addr    = 2'b00;
    usb_sloe    = 1'b0;
    usb_slrd    = 1'b0;
    usb_slwr    = 1'b0;
    usb_pktend  = 1'b0;
    usb_data_in = '0;
    rx_valid_w  = '0;
    rx_data_w   = '0;
    tx_ready_w  = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          ptr_d   = gnt_slot + 2'd1;
          ch_d    = gnt_slot[0];
          burst_d = '0;
          if (!gnt_slot[1])                 state_d = RD_SEL;
          else if (tx_valid_w[gnt_slot[0]]) state_d = WR;
          else                              state_d = PKTEND;
        end
      end
      RD_SEL: begin
        // One turnaround cycle so the FX2 drives the bus before the first read.
        usb_addr = {1'b0, ch_q};
        usb_sloe = 1'b1;
        state_d  = RD;
      end
      RD: begin
        usb_addr                             = {1'b0, ch_q};
        usb_sloe                             = 1'b1;
        rx_data_w[int'(ch_q)*WIDTH +: WIDTH] = usb_data_out;
        rx_valid_w[ch_q]                     = !usb_ep_empty[ch_q];
        usb_slrd                             = !usb_ep_empty[ch_q] && rx_ready_w[ch_q];
        if (usb_slrd) begin
          burst_d = burst_q + 9'd1;
          if (burst_d == 9'(BURST)) state_d = GAP;
        end else begin
          state_d = GAP;
        end
      end
      WR: begin
        usb_addr         = {1'b1, ch_q};
        usb_data_in      = tx_data_w[int'(ch_q)*WIDTH +: WIDTH];
        usb_slwr         = tx_valid_w[ch_q] && !usb_ep_full[ch_q];
        tx_ready_w[ch_q] = usb_slwr;
        if (usb_slwr) begin
          burst_d = burst_q + 9'd1;
          if (burst_d == 9'(BURST)) state_d = GAP;
        end else begin
          state_d = GAP;
        end
      end
      PKTEND: begin
        usb_addr   = {1'b1, ch_q};
        usb_pktend = 1'b1;
        state_d    = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-TX-channel packet fill and idle tracking; a write always beats the timeout.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      pcnt_d[c] = pcnt_q[c];
      idle_d[c] = idle_q[c];
      if (usb_pktend && ch_q == 1'(c)) begin
        pcnt_d[c] = '0;
        idle_d[c] = '0;
      end else if (usb_slwr && ch_q == 1'(c)) begin
        idle_d[c] = '0;
        pcnt_d[c] = (pcnt_q[c] == PCW'(PKT_WORDS - 1)) ? '0 : pcnt_q[c] + PCW'(1);
      end else if (pcnt_q[c] != '0 && !flush_due[c]) begin
        idle_d[c] = idle_q[c] + IW'(1);
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      ch_q    <= 1'b0;
      burst_q <= '0;
      for (int c = 0; c < 2; c++) begin
        pcnt_q[c] <= '0;
        idle_q[c] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      burst_q <= burst_d;
      for (int c = 0; c < 2; c++) begin
        pcnt_q[c] <= pcnt_d[c];
        idle_q[c] <= idle_d[c];
      end
    end
  end

  assign rx_valid = rx_valid_w[NUM_CH-1:0];
  assign tx_ready = tx_ready_w[NUM_CH-1:0];
  assign rx_data  = rx_data_w[NUM_CH*WIDTH-1:0];

endmodule

// File: tb/tb_usb_fifo_arbiter.sv
// tb_usb_fifo_arbiter: directed scenarios against a transaction-level model of the
// arbiter plus FX2 FIFO and stream source/sink models.
module tb_usb_fifo_arbiter;

  localparam int W = 8, NCH = 2, BURST = 4, PKT = 8, FT = 16;
  localparam int PH_IDLE = 0, PH_SEL = 1, PH_RD = 2, PH_WR = 3, PH_PE = 4, PH_GAP = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    usb_addr;
  logic          usb_sloe, usb_slrd, usb_slwr, usb_pktend;
  logic [W-1:0]  usb_data_in, usb_data_out;
  logic [1:0]    usb_ep_empty;
  logic [1:0]    usb_ep_full = 2'b00;
  logic [15:0]   rx_data, tx_data;
  logic [1:0]    rx_valid, tx_valid, tx_ready;
  logic [1:0]    rx_ready = 2'b00;

  // FX2 OUT FIFOs (host data waiting for the FPGA): bench pushes, DUT reads pop.
  logic [7:0] out_mem [2][64];
  int         out_wp [2] = '{0, 0};
  int         out_rp [2] = '{0, 0};
  // FX2 IN side capture and TX stream sources (word k of channel c is base_c + k).
  logic [7:0] in_mem [2][64];
  int         in_n [2]    = '{0, 0};
  int         tx_goal [2] = '{0, 0};
  int         tx_seq [2]  = '{0, 0};

  assign usb_ep_empty[0] = (out_wp[0] == out_rp[0]);
  assign usb_ep_empty[1] = (out_wp[1] == out_rp[1]);
  assign usb_data_out    = usb_addr[1] ? 8'h00 : out_mem[usb_addr[0]][out_rp[usb_addr[0]]];
  assign tx_valid        = {tx_seq[1] < tx_goal[1], tx_seq[0] < tx_goal[0]};
  assign tx_data         = {8'(8'hC0 + tx_seq[1]), 8'(8'hA0 + tx_seq[0])};

  usb_fifo_arbiter #(.WIDTH(W), .NUM_CH(NCH), .BURST(BURST), .PKT_WORDS(PKT),
                     .FLUSH_TIMEOUT(FT)) dut (
    .clk(clk), .reset(rst_n), .usb_addr(usb_addr), .usb_sloe(usb_sloe),
    .usb_slrd(usb_slrd), .usb_slwr(usb_slwr), .usb_pktend(usb_pktend),
    .usb_data_in(usb_data_in), .usb_data_out(usb_data_out),
    .usb_ep_empty(usb_ep_empty), .usb_ep_full(usb_ep_full),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: phase of the current grant, owner, words moved, next slot to try,
  // and per TX channel the packet fill (mod PKT) and cycles since the last write.
  int m_ph = PH_IDLE, m_ch = 0, m_cnt = 0, m_ptr = 0;
  int m_pc [2]    = '{0, 0};
  int m_since [2] = '{0, 0};

  // Expected outputs for the current cycle and pre-edge snapshots.
  logic [1:0]  e_addr, e_rxv, e_txr;
  logic        e_sloe, e_rd, e_wr, e_pe;
  logic [7:0]  e_din;
  logic [15:0] e_rxd;
  logic [1:0]  s_empty, s_rdy, s_txv, s_full, s_addr;
  logic        s_erd, s_ewr, s_epe, s_drd, s_dwr;
  logic [7:0]  s_din;

  // DUT activity statistics and transfer-run log.
  int cyc_n = 0, n_slrd = 0, n_slwr = 0, n_pe = 0, n_sloe = 0;
  int pe_cycle = 0, last_wr_cycle = 0;
  logic [1:0] pe_addr = 2'b00;
  logic [7:0] rx_mem [256];
  int rx_n = 0;
  int run_slot [64], run_len [64], run_start [64];
  int n_runs = 0;
  logic prev_xf = 1'b0;

  // Compare process: predict outputs from the model and current inputs, compare, snapshot.
  always @(negedge clk) begin
    cyc_n++;
    e_addr = 2'b00; e_sloe = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_pe = 1'b0;
    e_din = 8'h00; e_rxv = 2'b00; e_rxd = 16'h0000; e_txr = 2'b00;
    if (!rst_n) begin
      m_ph = PH_IDLE; m_ch = 0; m_cnt = 0; m_ptr = 0;
      m_pc = '{0, 0}; m_since = '{0, 0};
    end else begin
      case (m_ph)
        PH_SEL: begin e_addr = 2'(m_ch); e_sloe = 1'b1; end
        PH_RD: begin
          e_addr = 2'(m_ch); e_sloe = 1'b1;
          e_rxd[m_ch*8 +: 8] = usb_data_out;
          e_rxv[m_ch] = !usb_ep_empty[m_ch];
          e_rd = !usb_ep_empty[m_ch] && rx_ready[m_ch];
        end
        PH_WR: begin
          e_addr = 2'(2 + m_ch);
          e_din = tx_data[m_ch*8 +: 8];
          e_wr = tx_valid[m_ch] && !usb_ep_full[m_ch];
          e_txr[m_ch] = e_wr;
        end
        PH_PE: begin e_addr = 2'(2 + m_ch); e_pe = 1'b1; end
        default: ;
      endcase
    end
    check("ctl", {usb_addr, usb_sloe, usb_slrd, usb_slwr, usb_pktend},
          {e_addr, e_sloe, e_rd, e_wr, e_pe});
    check("data_in", usb_data_in, e_din);
    check("rx_stream", {rx_valid, rx_data}, {e_rxv, e_rxd});
    check("tx_ready", tx_ready, e_txr);
    s_empty = usb_ep_empty; s_rdy = rx_ready; s_txv = tx_valid; s_full = usb_ep_full;
    s_erd = e_rd; s_ewr = e_wr; s_epe = e_pe;
    s_drd = usb_slrd; s_dwr = usb_slwr; s_addr = usb_addr; s_din = usb_data_in;
    if (rst_n) begin
      n_slrd += int'(usb_slrd); n_slwr += int'(usb_slwr);
      n_pe += int'(usb_pktend); n_sloe += int'(usb_sloe);
      if (usb_pktend) begin pe_cycle = cyc_n; pe_addr = usb_addr; end
      if (usb_slwr) last_wr_cycle = cyc_n;
      if (rx_valid[0] && rx_ready[0]) begin rx_mem[rx_n] = rx_data[7:0]; rx_n++; end
      if (usb_slrd || usb_slwr) begin
        if (prev_xf && n_runs > 0 && run_slot[n_runs-1] == int'(usb_addr)) run_len[n_runs-1]++;
        else begin
          run_slot[n_runs] = int'(usb_addr); run_len[n_runs] = 1;
          run_start[n_runs] = cyc_n; n_runs++;
        end
      end
    end
    prev_xf = rst_n && (usb_slrd || usb_slwr);
  end

  // Edge process: FX2/stream environment reacts to DUT strobes; model advances.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (s_drd) out_rp[s_addr[0]]++;
      if (s_dwr) begin
        in_mem[s_addr[0]][in_n[s_addr[0]]] = s_din;
        in_n[s_addr[0]]++;
        tx_seq[s_addr[0]]++;
      end
      begin
        logic fl [2];
        logic found;
        for (int c = 0; c < 2; c++) fl[c] = (m_pc[c] != 0) && (m_since[c] >= FT);
        case (m_ph)
          PH_IDLE: begin
            found = 1'b0;
            for (int i = 0; i < 4; i++) begin
              int slot, c;
              logic el;
              slot = (m_ptr + i) % 4;
              c = slot % 2;
              el = (slot < 2) ? (!s_empty[c] && s_rdy[c]) : (!s_full[c] && (s_txv[c] || fl[c]));
              if (!found && el) begin
                found = 1'b1;
                m_ptr = (slot + 1) % 4; m_ch = c; m_cnt = 0;
                m_ph = (slot < 2) ? PH_SEL : (s_txv[c] ? PH_WR : PH_PE);
              end
            end
          end
          PH_SEL: m_ph = PH_RD;
          PH_RD:  if (s_erd) begin m_cnt++; if (m_cnt == BURST) m_ph = PH_GAP; end else m_ph = PH_GAP;
          PH_WR:  if (s_ewr) begin m_cnt++; if (m_cnt == BURST) m_ph = PH_GAP; end else m_ph = PH_GAP;
          PH_PE:  m_ph = PH_GAP;
          default: m_ph = PH_IDLE;
        endcase
        for (int c = 0; c < 2; c++) begin
          if (s_epe && m_ch == c) begin m_pc[c] = 0; m_since[c] = 0; end
          else if (s_ewr && m_ch == c) begin m_pc[c] = (m_pc[c] + 1) % PKT; m_since[c] = 0; end
          else if (m_since[c] < 100000) m_since[c]++;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push(input int c, input logic [7:0] v);
    out_mem[c][out_wp[c]] = v;
    out_wp[c]++;
  endtask

  int b_rd, b_wr, b_pe, b_sloe, b_runs, b_rx, b_in, guard;

  task automatic mark();
    b_rd = n_slrd; b_wr = n_slwr; b_pe = n_pe; b_sloe = n_sloe;
    b_runs = n_runs; b_rx = rx_n;
  endtask

  initial begin
    #3 rst_n = 1'b0;
    step(3);
    check("reset_outputs", {usb_addr, usb_sloe, usb_slrd, usb_slwr, usb_pktend,
          usb_data_in, rx_valid, tx_ready}, 0);
    rst_n = 1'b1;
    step(2);

    // A: three words in EP2 -> one turnaround, three reads, exit on empty.
    mark();
    rx_ready = 2'b11;
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    step(12);
    check("A_slrd_pulses", n_slrd - b_rd, 3);
    check("A_rx_count", rx_n - b_rx, 3);
    check("A_rx_words", {rx_mem[b_rx], rx_mem[b_rx+1], rx_mem[b_rx+2]}, 24'h112233);
    check("A_sloe_cycles", n_sloe - b_sloe, 5);

    // B: BURST=4, RX0 and TX0 both busy -> alternating 4-word grants.
    mark();
    for (int i = 0; i < 12; i++) push(0, 8'(8'h40 + i));
    tx_goal[0] += 12;
    step(70);
    check("B_runs", n_runs - b_runs, 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("B_run%0d_slot", k), run_slot[b_runs+k], (k % 2 == 0) ? 2 : 0);
      check($sformatf("B_run%0d_len", k), run_len[b_runs+k], 4);
      if (k > 0)
        check($sformatf("B_run%0d_spacing", k), run_start[b_runs+k] - run_start[b_runs+k-1],
              (k % 2 == 1) ? 7 : 6);
    end
    check("B_rx_last", rx_mem[b_rx+11], 8'h4B);
    check("B_flush_once", n_pe - b_pe, 1);
    check("B_flush_addr", pe_addr, 2);

    // C: five TX0 words then idle -> single PKTEND on EP6 after the timeout.
    mark();
    b_in = in_n[0];
    tx_goal[0] += 5;
    step(12);
    check("C_words", n_slwr - b_wr, 5);
    check("C_model_pcnt", m_pc[0], 5);
    step(30);
    check("C_pktend_once", n_pe - b_pe, 1);
    check("C_pktend_addr", pe_addr, 2);
    check("C_pktend_delay", pe_cycle - last_wr_cycle, 18);
    check("C_model_pcnt_clear", m_pc[0], 0);
    check("C_last_word", in_mem[0][b_in+4], 8'(8'hA0 + 16));

    // D: exactly PKT_WORDS words on TX1 -> auto-commit wrap, no PKTEND.
    mark();
    tx_goal[1] += 8;
    step(50);
    check("D_words", n_slwr - b_wr, 8);
    check("D_no_pktend", n_pe - b_pe, 0);
    check("D_model_pcnt_wrap", m_pc[1], 0);
    check("D_last_word", in_mem[1][7], 8'hC7);

    // E: EP8 fills mid-burst -> write strobe drops at once, GAP, later rearbitration.
    mark();
    b_in = in_n[1];
    tx_goal[1] += 10;
    guard = 0;
    while ((n_slwr - b_wr) < 2 && guard < 30) begin step(1); guard++; end
    check("E_wait_two_words", (n_slwr - b_wr) >= 2, 1);
    usb_ep_full[1] = 1'b1;
    #1;
    check("E_full_same_cycle", {usb_addr, usb_slwr, tx_ready}, {2'd3, 1'b0, 2'b00});
    step(1);
    check("E_gap", {usb_addr, usb_sloe, usb_slrd, usb_slwr, usb_pktend}, 0);
    step(4);
    check("E_held_while_full", n_slwr - b_wr, 2);
    usb_ep_full[1] = 1'b0;
    step(45);
    check("E_all_words", in_n[1] - b_in, 10);
    check("E_last_word", in_mem[1][b_in+9], 8'(8'hC0 + 17));
    check("E_runs", n_runs - b_runs, 3);
    check("E_run_lens", {8'(run_len[b_runs]), 8'(run_len[b_runs+1]), 8'(run_len[b_runs+2])},
          24'h020404);
    check("E_flush_addr", {8'(n_pe - b_pe), 6'd0, pe_addr}, 16'h0103);

    // F: reset during a read burst -> strobes drop at once; RX0 wins first after release.
    mark();
    for (int i = 0; i < 6; i++) push(0, 8'(8'h60 + i));
    guard = 0;
    while ((n_slrd - b_rd) < 2 && guard < 30) begin step(1); guard++; end
    check("F_wait_two_reads", (n_slrd - b_rd) >= 2, 1);
    rst_n = 1'b0;
    tx_goal[0] += 1;
    #1;
    check("F_reset_immediate", {usb_addr, usb_sloe, usb_slrd, usb_slwr, rx_valid}, 0);
    step(2);
    rst_n = 1'b1;
    b_runs = n_runs;
    step(30);
    check("F_first_slot", run_slot[b_runs], 0);
    check("F_first_len", run_len[b_runs], 4);
    check("F_second_slot", run_slot[b_runs+1], 2);
    check("F_rx_total", rx_n - b_rx, 6);
    check("F_rx_no_skip", {rx_mem[b_rx+2], rx_mem[b_rx+5]}, 16'h6265);
    step(25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
